// File: rtl/prach_pkg.sv
// Shared types and constants for the PRACH reshape burst scheduler.
package prach_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        BURST
    } state_t;

    localparam int ChnWidth = 8;

    function automatic int beat_cnt_width(input int size);
        return (2 * size > 1) ? $clog2(2 * size) : 1;
    endfunction

endpackage

// File: rtl/prach_reshape_sched_arb.sv
// Combinational round-robin pick: first eligible source at or above ptr, wrapping.
module prach_rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [PW-1:0]     ptr,
    output logic              gnt_valid,
    output logic [PW-1:0]     gnt_idx
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!gnt_valid && eligible[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/prach_reshape_sched.sv
// Grants the shared reshape datapath to one source per 2*SIZE-beat burst,
// round-robin, and drives the datapath inputs one cycle after each pop.
module prach_reshape_sched
    import prach_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int NUM_CH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 resync,
    input  logic [NUM_CH-1:0]    cfg_ch_mask,
    input  logic [NUM_CH-1:0]    src_req,
    input  logic [NUM_CH*16-1:0] src_dq1,
    input  logic [NUM_CH*16-1:0] src_dq2,
    output logic [NUM_CH-1:0]    src_rd,
    output logic [15:0]          dout_dq1,
    output logic [15:0]          dout_dq2,
    output logic                 dout_dv,
    output logic [ChnWidth-1:0]  dout_chn,
    output logic                 sync_out,
    output logic                 busy,
    output logic                 burst_done
);

    localparam int PW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW   = beat_cnt_width(SIZE);
    localparam int LAST = 2 * SIZE - 1;

    state_t            state;
    logic [PW-1:0]     g;
    logic [PW-1:0]     rr;
    logic [PW-1:0]     rr_next;
    logic [BW-1:0]     beat;
    logic              sync_pend;
    logic              enable_d;
    logic              arb_valid;
    logic [PW-1:0]     arb_idx;
    logic [NUM_CH-1:0] eligible;
    logic              first_beat;
    logic              last_beat;
    logic [15:0]       dq1_arr [NUM_CH];
    logic [15:0]       dq2_arr [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign dq1_arr[k] = src_dq1[16*k +: 16];
        assign dq2_arr[k] = src_dq2[16*k +: 16];
    end

    assign eligible   = src_req & cfg_ch_mask;
    assign busy       = (state == BURST);
    assign first_beat = busy && (beat == '0);
    assign last_beat  = busy && (beat == BW'(LAST));
    assign rr_next    = (arb_idx == PW'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;

    prach_rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_arb (
        .eligible (eligible),
        .ptr      (rr),
        .gnt_valid(arb_valid),
        .gnt_idx  (arb_idx)
    );

    // Gated by rst so a reset mid-burst stops popping in the same cycle.
    always_comb begin
        src_rd = '0;
        if (busy && !rst) src_rd[g] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            g          <= '0;
            rr         <= '0;
            beat       <= '0;
            sync_pend  <= 1'b1;
            enable_d   <= 1'b0;
            dout_dq1   <= '0;
            dout_dq2   <= '0;
            dout_dv    <= 1'b0;
            dout_chn   <= '0;
            sync_out   <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            enable_d   <= enable;
            dout_dv    <= busy;
            sync_out   <= first_beat && sync_pend;
            burst_done <= last_beat;
            if (busy) begin
                dout_dq1 <= dq1_arr[g];
                dout_dq2 <= dq2_arr[g];
                dout_chn <= ChnWidth'(g);
            end
            // A new request wins over the clear so coincident resync carries over.
            if ((enable && !enable_d) || resync) begin
                sync_pend <= 1'b1;
            end else if (first_beat) begin
                sync_pend <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (enable) state <= ARB;
                end
                ARB: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (arb_valid) begin
                        g     <= arb_idx;
                        rr    <= rr_next;
                        beat  <= '0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    beat <= beat + 1'b1;
                    if (beat == BW'(LAST)) state <= ARB;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/prach_reshape_sched.md
Name: prach_reshape_sched

Overview:
- Burst scheduler in front of the PRACH channel-reshape datapath.
- Shares the single reshape datapath among NUM_CH per-carrier sample sources.
- Grants one source at a time, round-robin, for exactly one burst of 2*SIZE contiguous sample pairs (the reshape frame).
- Drives the datapath's dq1/dq2/dv/chn/sync inputs; emits sync at the first beat after enable and on request.

Parameters:
- SIZE, 8, half-burst length; one burst is 2*SIZE beats; must match the reshape datapath's SIZE.
- NUM_CH, 4, number of requesting sources; 1..256.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  scheduling enable; sampled in IDLE/ARB only
- resync  in  1  one-cycle pulse; next burst start carries sync
- cfg_ch_mask  in  NUM_CH  1 = source eligible; sampled in ARB
- src_req  in  NUM_CH  source k holds >= 2*SIZE pairs (FWFT)
- src_dq1  in  NUM_CH*16  packed, source k at [16k+15:16k], valid with src_req
- src_dq2  in  NUM_CH*16  packed, same layout
- src_rd  out  NUM_CH  one-hot read strobe; pops current pair of granted source
- dout_dq1  out  16  to datapath din_dq1
- dout_dq2  out  16  to datapath din_dq2
- dout_dv  out  1  beat valid
- dout_chn  out  8  granted source index, zero-extended
- sync_out  out  1  one-cycle frame sync, coincident with first dout_dv of a burst
- busy  out  1  1 while in BURST
- burst_done  out  1  one-cycle pulse on the last dout_dv beat of a burst

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; rr pointer 0; sync_pend 1; all outputs 0, including src_rd.
- FSM:
  - IDLE: if enable, go to ARB; else stay.
  - ARB: if !enable, go to IDLE. Else compute eligible = src_req & cfg_ch_mask.
    - If eligible != 0, pick the first set bit at or above rr pointer, wrapping. Latch its index g, set rr pointer to (g+1) mod NUM_CH, load beat counter 0, go to BURST.
    - If eligible == 0, stay in ARB.
  - BURST: src_rd[g]=1 every cycle (combinational from state and g). Beat counter increments 0..2*SIZE-1. At 2*SIZE-1, go to ARB.
- Minimum gap between bursts: 1 cycle (ARB).
- The burst is never interrupted by enable, mask, or src_req changes. A source granted must supply 2*SIZE pairs; src_req is not rechecked inside the burst.
- Output pipeline, 1-cycle latency registered from the src_rd cycle:
  - dout_dq1/dq2 = selected source data.
  - dout_dv = src_rd != 0.
  - dout_chn = g.
  - When dv=0, dq1/dq2/chn hold their last values.
- sync_pend:
  - Set by reset, by a rising edge of enable, or by resync in any state.
  - On the first BURST cycle, if sync_pend is set, sync_out is 1 on the next cycle (aligned with the first dout_dv) and sync_pend clears.
  - If resync and the first BURST cycle coincide, sync is emitted and sync_pend remains set for the following burst.
- burst_done: registered, aligned with beat 2*SIZE-1 of dout_dv.
- busy = (state == BURST), combinational.
- Reset mid-burst: immediate abort, src_rd drops in the same cycle as rst, outputs cleared next edge. No partial-burst recovery.
- NUM_CH=1: pointer always 0; back-to-back bursts every 2*SIZE+1 cycles.

Decomposition:
- Package prach_pkg:
  - state enum (IDLE, ARB, BURST).
  - ChnWidth = 8 constant.
  - function beat_cnt_width(SIZE) = $clog2(2*SIZE).
- Sub-module prach_rr_arbiter (NUM_CH):
  - Inputs: eligible vector and pointer.
  - Outputs: grant valid and index.
  - Combinational; the pointer register stays in the scheduler.

Test Plan:
- Single source: NUM_CH=4, SIZE=8, mask=4'hF, only src_req[1]=1, enable rises at t0 -> src_rd[1] high for 16 cycles starting t0+2; dout_dv 16 cycles starting t0+3; dout_chn=1; sync_out only on the first beat; burst_done on beat 16.
- Round-robin: src_req=4'b0101 held, 3 bursts -> dout_chn sequence 0,2,0; 1-cycle gap between bursts; sync only on the first.
- Mask: src_req=4'hF, mask=4'b1010 -> grant order 1,3,1. Mask changed to 4'b0001 mid-burst -> current burst completes, next grant 0.
- Enable drop: enable=0 on beat 5 of burst -> all 16 beats still delivered, then IDLE. Re-enable -> next burst carries sync_out.
- Reset mid-burst: rst on beat 7 -> src_rd=0 that cycle; dout_dv, sync_out, busy, burst_done=0 next cycle; rr pointer 0 on restart.
- Resync: resync pulse during burst on channel 2 -> next burst (channel 3) starts with sync_out=1 on its first dv beat.
